// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter sharing one BRAM read port, with optional burst lock and tagged return path.
// Optional stall statistic enabled by defining ARB_STATS_EN.
module bram_read_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_LOCK     = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [ADDR_WIDTH-1:0]         bram_rd_addr,
    input  logic [DATA_WIDTH-1:0]         bram_rd_data,
    output logic                          busy,
    output logic [31:0]                   stall_count
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t                 state_reg;
    logic [ID_W-1:0]        owner_reg;
    logic [ID_W-1:0]        last_winner_reg;
    logic [CNT_W-1:0]       lock_cnt_reg;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [READ_LATENCY-1:0] pipe_valid_reg;
    logic [ID_W-1:0]        pipe_id_reg [READ_LATENCY];

    logic [ADDR_WIDTH-1:0]  addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0]     owner_onehot;
    logic [NUM_REQ-1:0]     excl_mask;
    logic [NUM_REQ-1:0]     cand;
    logic                   lock_active;
    logic                   timeout;
    logic                   win_found;
    logic                   win_lock;
    logic [ID_W-1:0]        win_id;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    int                     idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]     = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign owner_onehot[gi] = (owner_reg == ID_W'(gi));
            assign gnt[gi]          = win_found && (win_id == ID_W'(gi));
            assign rd_valid[gi]     = pipe_valid_reg[READ_LATENCY-1] &&
                                      (pipe_id_reg[READ_LATENCY-1] == ID_W'(gi));
        end
    endgenerate

    assign lock_active = (state_reg == LOCKED) && |(req_lock & owner_onehot) &&
                         (lock_cnt_reg < CNT_W'(MAX_LOCK));
    assign timeout     = (state_reg == LOCKED) && (lock_cnt_reg >= CNT_W'(MAX_LOCK));
    // A timed-out owner steps aside only when someone else is actually waiting.
    assign excl_mask   = (timeout && |(req & ~owner_onehot)) ? owner_onehot : '0;
    assign cand        = req & ~excl_mask;
    assign win_lock    = |(req_lock & gnt);

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        if (lock_active) begin
            win_found = |(req & owner_onehot);
            win_id    = owner_reg;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(last_winner_reg) + k) % NUM_REQ;
                if (!win_found && cand[idx]) begin
                    win_found = 1'b1;
                    win_id    = ID_W'(idx);
                end
            end
        end
    end

    always_comb begin
        sel_addr = addr_reg;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) sel_addr = addr_arr[i];
        end
    end

    assign bram_rd_addr = sel_addr;
    assign rd_data      = bram_rd_data;
    assign busy         = |req || |pipe_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ARB;
            owner_reg       <= '0;
            last_winner_reg <= ID_W'(NUM_REQ - 1);
            lock_cnt_reg    <= '0;
            addr_reg        <= '0;
            pipe_valid_reg  <= '0;
            for (int s = 0; s < READ_LATENCY; s++) pipe_id_reg[s] <= '0;
        end else begin
            if (win_found) addr_reg <= sel_addr;
            pipe_valid_reg[0] <= win_found;
            pipe_id_reg[0]    <= win_id;
            for (int s = READ_LATENCY - 1; s > 0; s--) begin
                pipe_valid_reg[s] <= pipe_valid_reg[s-1];
                pipe_id_reg[s]    <= pipe_id_reg[s-1];
            end
            if (lock_active) begin
                // Bubbles (owner idle but still locking) count against the lock budget too.
                if (win_found) last_winner_reg <= owner_reg;
                if (lock_cnt_reg < CNT_W'(MAX_LOCK)) lock_cnt_reg <= lock_cnt_reg + 1'b1;
            end else begin
                if (win_found) last_winner_reg <= win_id;
                if (win_found && win_lock) begin
                    state_reg    <= LOCKED;
                    owner_reg    <= win_id;
                    lock_cnt_reg <= CNT_W'(1);
                end else begin
                    state_reg    <= ARB;
                    lock_cnt_reg <= '0;
                end
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] stall_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg <= '0;
        end else if (|(req & ~gnt) && (stall_count_reg != 32'hFFFF_FFFF)) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign stall_count = stall_count_reg;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed bench for bram_read_arbiter: one instance at latency 1 and one at latency 2, both MAX_LOCK=4.
module tb_bram_read_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
`ifdef ARB_STATS_EN
    localparam logic [31:0] EXP_STALL = 32'd1;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    req = '0;
    logic [2:0]    req_lock = '0;
    logic [3*AW-1:0] req_addr = '0;

    logic [2:0]    gnt, rd_valid, gnt2, rd_valid2;
    logic [DW-1:0] rd_data, rd_data2, stall_count, stall_count2;
    logic [DW-1:0] bram_rd_data = '0;
    logic [DW-1:0] bram_q1 = '0, bram_rd_data2 = '0;
    logic [AW-1:0] bram_rd_addr, bram_rd_addr2;
    logic          busy, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bram_read_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .READ_LATENCY(1), .MAX_LOCK(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_lock(req_lock),
        .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data), .bram_rd_addr(bram_rd_addr),
        .bram_rd_data(bram_rd_data), .busy(busy), .stall_count(stall_count));

    bram_read_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .READ_LATENCY(2), .MAX_LOCK(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_lock(req_lock),
        .gnt(gnt2), .rd_valid(rd_valid2), .rd_data(rd_data2), .bram_rd_addr(bram_rd_addr2),
        .bram_rd_data(bram_rd_data2), .busy(busy2), .stall_count(stall_count2));

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {18'b0, a};
    endfunction

    // BRAM models: one and two cycles of address-to-data latency.
    always @(posedge clk) begin
        bram_rd_data  <= memf(bram_rd_addr);
        bram_q1       <= memf(bram_rd_addr2);
        bram_rd_data2 <= bram_q1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check mid-cycle, return just after the next rising edge.
    task automatic cyc(input string tag, input logic [2:0] r, input logic [2:0] l,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [2:0] eg, input logic [AW-1:0] ea,
                       input logic [2:0] ev, input logic [AW-1:0] ed, input logic eb,
                       input bit chk2, input logic [2:0] ev2, input logic [AW-1:0] ed2);
        req = r; req_lock = l; req_addr = {a2, a1, a0};
        @(negedge clk);
        check({tag, "_gnt"}, 32'(gnt), 32'(eg));
        check({tag, "_addr"}, 32'(bram_rd_addr), 32'(ea));
        check({tag, "_rdv"}, 32'(rd_valid), 32'(ev));
        if (ev != 3'b000) check({tag, "_data"}, rd_data, memf(ed));
        check({tag, "_busy"}, 32'(busy), 32'(eb));
        if (chk2) begin
            check({tag, "_rdv2"}, 32'(rd_valid2), 32'(ev2));
            if (ev2 != 3'b000) check({tag, "_data2"}, rd_data2, memf(ed2));
        end
        $display("cycle %-6s req=%b lock=%b gnt=%b addr=%0d rd_valid=%b rd_valid2=%b",
                 tag, r, l, gnt, bram_rd_addr, rd_valid, rd_valid2);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        req = '0; req_lock = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rdv", 32'(rd_valid), 32'd0);
        check("rst_addr", 32'(bram_rd_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", stall_count, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Three-way round robin, addresses 10/20/30.
        cyc("rr0", 3'b111, 3'b000, 10, 20, 30, 3'b001, 10, 3'b000, 0,  1'b1, 1'b0, 0, 0);
        cyc("rr1", 3'b111, 3'b000, 10, 20, 30, 3'b010, 20, 3'b001, 10, 1'b1, 1'b0, 0, 0);
        cyc("rr2", 3'b111, 3'b000, 10, 20, 30, 3'b100, 30, 3'b010, 20, 1'b1, 1'b0, 0, 0);
        cyc("rr3", 3'b111, 3'b000, 10, 20, 30, 3'b001, 10, 3'b100, 30, 1'b1, 1'b0, 0, 0);
        cyc("rr4", 3'b000, 3'b000, 10, 20, 30, 3'b000, 10, 3'b001, 10, 1'b1, 1'b0, 0, 0);
        cyc("rr5", 3'b000, 3'b000, 10, 20, 30, 3'b000, 10, 3'b000, 0,  1'b0, 1'b0, 0, 0);

        // Single requester streaming addresses 5..9.
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("s%0d", i), 3'b010, 3'b000, 0, AW'(5 + i), 0, 3'b010, AW'(5 + i),
                (i == 0) ? 3'b000 : 3'b010, AW'(4 + i), 1'b1, 1'b0, 0, 0);
        end
        cyc("s5", 3'b000, 3'b000, 0, 9, 0, 3'b000, 9, 3'b010, 9, 1'b1, 1'b0, 0, 0);

        // Burst lock with MAX_LOCK=4, timeout hand-off, bubble, and release.
        do_reset();
        cyc("lk0", 3'b101, 3'b001, 40, 0, 50, 3'b001, 40, 3'b000, 0,  1'b1, 1'b0, 0, 0);
        cyc("lk1", 3'b101, 3'b001, 40, 0, 50, 3'b001, 40, 3'b001, 40, 1'b1, 1'b0, 0, 0);
        cyc("lk2", 3'b101, 3'b001, 40, 0, 50, 3'b001, 40, 3'b001, 40, 1'b1, 1'b0, 0, 0);
        cyc("lk3", 3'b101, 3'b001, 40, 0, 50, 3'b001, 40, 3'b001, 40, 1'b1, 1'b0, 0, 0);
        cyc("lk4", 3'b101, 3'b001, 40, 0, 50, 3'b100, 50, 3'b001, 40, 1'b1, 1'b0, 0, 0);
        cyc("lk5", 3'b101, 3'b001, 40, 0, 50, 3'b001, 40, 3'b100, 50, 1'b1, 1'b0, 0, 0);
        cyc("lk6", 3'b100, 3'b001, 40, 0, 50, 3'b000, 40, 3'b001, 40, 1'b1, 1'b0, 0, 0);
        cyc("lk7", 3'b100, 3'b000, 40, 0, 50, 3'b100, 50, 3'b000, 0,  1'b1, 1'b0, 0, 0);
        cyc("lk8", 3'b000, 3'b000, 40, 0, 50, 3'b000, 50, 3'b100, 50, 1'b1, 1'b0, 0, 0);
        cyc("lk9", 3'b000, 3'b000, 40, 0, 50, 3'b000, 50, 3'b000, 0,  1'b0, 1'b0, 0, 0);

        // Alternating requesters; second instance returns two cycles after grant.
        cyc("al0", 3'b001, 3'b000, 100, 200, 0, 3'b001, 100, 3'b000, 0,   1'b1, 1'b1, 3'b000, 0);
        cyc("al1", 3'b010, 3'b000, 100, 200, 0, 3'b010, 200, 3'b001, 100, 1'b1, 1'b1, 3'b000, 0);
        cyc("al2", 3'b001, 3'b000, 100, 200, 0, 3'b001, 100, 3'b010, 200, 1'b1, 1'b1, 3'b001, 100);
        cyc("al3", 3'b010, 3'b000, 100, 200, 0, 3'b010, 200, 3'b001, 100, 1'b1, 1'b1, 3'b010, 200);
        cyc("al4", 3'b000, 3'b000, 100, 200, 0, 3'b000, 200, 3'b010, 200, 1'b1, 1'b1, 3'b001, 100);
        cyc("al5", 3'b000, 3'b000, 100, 200, 0, 3'b000, 200, 3'b000, 0,   1'b0, 1'b1, 3'b010, 200);
        cyc("al6", 3'b000, 3'b000, 100, 200, 0, 3'b000, 200, 3'b000, 0,   1'b0, 1'b1, 3'b000, 0);

        // Reset one cycle after a grant: no late return afterwards, pointer restarts.
        cyc("mr0", 3'b001, 3'b000, 7, 0, 0, 3'b001, 7, 3'b000, 0, 1'b1, 1'b1, 3'b000, 0);
        req = '0; rst_n = 1'b0;
        #1;
        check("mr_rdv", 32'(rd_valid), 32'd0);
        check("mr_busy2", 32'(busy2), 32'd0);
        @(negedge clk); @(posedge clk); #1 rst_n = 1'b1;
        cyc("mr1", 3'b000, 3'b000, 7, 0, 0, 3'b000, 0, 3'b000, 0, 1'b0, 1'b1, 3'b000, 0);
        cyc("mr2", 3'b000, 3'b000, 7, 0, 0, 3'b000, 0, 3'b000, 0, 1'b0, 1'b1, 3'b000, 0);
        cyc("mr3", 3'b111, 3'b000, 10, 20, 30, 3'b001, 10, 3'b000, 0, 1'b1, 1'b1, 3'b000, 0);

        // One contested cycle for the stall statistic.
        do_reset();
        cyc("st0", 3'b011, 3'b000, 1, 2, 0, 3'b001, 1, 3'b000, 0, 1'b1, 1'b0, 0, 0);
        cyc("st1", 3'b010, 3'b000, 1, 2, 0, 3'b010, 2, 3'b001, 1, 1'b1, 1'b0, 0, 0);
        cyc("st2", 3'b000, 3'b000, 1, 2, 0, 3'b000, 2, 3'b010, 2, 1'b1, 1'b0, 0, 0);
        check("stall_count", stall_count, EXP_STALL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
